// File: rtl/branch_predictor_gshare.sv
// Gshare-style conditional branch predictor: global history register plus a table of saturating counters.
// Define GSHARE_XOR_EN to hash the PC with the history by XOR instead of concatenating them.
module branch_predictor_gshare #(
    parameter int HIST_W = 4,
    parameter int IDX_W  = 7,
    parameter int CNT_W  = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ce_i,
    input  logic              lk_valid_i,
    input  logic [31:0]       lk_pc_i,
    output logic              pred_taken_o,
    output logic [IDX_W-1:0]  pred_idx_o,
    output logic [HIST_W-1:0] pred_ghr_o,
    input  logic              upd_valid_i,
    input  logic [IDX_W-1:0]  upd_idx_i,
    input  logic [HIST_W-1:0] upd_ghr_i,
    input  logic              upd_taken_i,
    input  logic              upd_mispredict_i,
    output logic              ready_o,
    output logic [HIST_W-1:0] ghr_o
);
    localparam int DEPTH = 1 << IDX_W;
    localparam logic [CNT_W-1:0] WEAK_T  = {1'b1, {(CNT_W-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [HIST_W-1:0] ghr_q, ghr_d;
    logic [CNT_W-1:0]  pht_q [DEPTH];

    logic [IDX_W-1:0]  lk_idx;
    logic [CNT_W-1:0]  lk_cnt, upd_cnt, upd_cnt_nxt;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [CNT_W-1:0]  wr_cnt;
    logic              unused_bits;

`ifdef GSHARE_XOR_EN
    assign lk_idx = lk_pc_i[IDX_W+1:2] ^ IDX_W'(ghr_q);
`else
    if (IDX_W > HIST_W) begin : g_cat
        assign lk_idx = {lk_pc_i[IDX_W-HIST_W+1:2], ghr_q};
    end else begin : g_ghr
        assign lk_idx = ghr_q;
    end
`endif

    // Only some PC bits and the oldest returned history bit feed the logic.
    assign unused_bits = ^{lk_pc_i, upd_ghr_i[HIST_W-1]};

    assign lk_cnt       = pht_q[lk_idx];
    assign pred_taken_o = (state_q == S_RUN) && lk_cnt[CNT_W-1];
    assign pred_idx_o   = lk_idx;
    assign pred_ghr_o   = ghr_q;
    assign ready_o      = (state_q == S_RUN);
    assign ghr_o        = ghr_q;

    assign upd_cnt = pht_q[upd_idx_i];
    always_comb begin
        upd_cnt_nxt = upd_cnt;
        if (upd_taken_i) begin
            if (upd_cnt != CNT_MAX) upd_cnt_nxt = upd_cnt + CNT_W'(1);
        end else begin
            if (upd_cnt != '0) upd_cnt_nxt = upd_cnt - CNT_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ghr_d   = ghr_q;
        wr_en   = 1'b0;
        wr_idx  = ptr_q;
        wr_cnt  = WEAK_T;
        if (ce_i) begin
            case (state_q)
                S_INIT: begin
                    wr_en = 1'b1;
                    ptr_d = ptr_q + IDX_W'(1);
                    if (ptr_q == '1) state_d = S_RUN;
                end
                default: begin
                    if (upd_valid_i) begin
                        wr_en  = 1'b1;
                        wr_idx = upd_idx_i;
                        wr_cnt = upd_cnt_nxt;
                    end
                    // A mispredict repair replaces any speculative shift from this cycle.
                    if (upd_valid_i && upd_mispredict_i)
                        ghr_d = {upd_ghr_i[HIST_W-2:0], upd_taken_i};
                    else if (lk_valid_i)
                        ghr_d = {ghr_q[HIST_W-2:0], pred_taken_o};
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= S_INIT;
            ptr_q   <= '0;
            ghr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ghr_q   <= ghr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i && wr_en) pht_q[wr_idx] <= wr_cnt;
    end
endmodule

// File: doc/branch_predictor_gshare.md
BRANCH_PREDICTOR_GSHARE -- requirements
Module: branch_predictor_gshare

Interface
REQ-001 Parameter HIST_W, default 4: global history register (GHR) width; legal range 2..IDX_W.
REQ-002 Parameter IDX_W, default 7: pattern history table (PHT) index width; PHT depth = 2^IDX_W entries.
REQ-003 Parameter CNT_W, default 2: saturating counter width; legal range 2..4.
REQ-004 clk  in  1  single clock; all state changes on posedge.
REQ-005 rst  in  1  reset; synchronous, active-low.
REQ-006 CE  in  1  clock enable; 0 freezes all state.
REQ-007 lk_valid  in  1  conditional-branch lookup request this cycle.
REQ-008 lk_pc  in  32  PC of the looked-up branch.
REQ-009 pred_taken  out  1  prediction; combinational from lk_pc and current state.
REQ-010 pred_idx  out  IDX_W  PHT index used for this lookup; carried down the pipe.
REQ-011 pred_ghr  out  HIST_W  GHR snapshot used for this lookup; carried down the pipe.
REQ-012 upd_valid  in  1  resolved-branch update request.
REQ-013 upd_idx  in  IDX_W  pred_idx returned at lookup time.
REQ-014 upd_ghr  in  HIST_W  pred_ghr returned at lookup time.
REQ-015 upd_taken  in  1  actual outcome (1 = taken).
REQ-016 upd_mispredict  in  1  predicted direction differed from actual.
REQ-017 ready  out  1  1 = table initialised; lookups and updates honoured.
REQ-018 ghr  out  HIST_W  current speculative GHR (debug).

Function
REQ-019 FSM states INIT and RUN; INIT entered on reset; INIT->RUN after the write to entry 2^IDX_W-1.
REQ-020 INIT writes WEAK_T = 2^(CNT_W-1) to one entry per CE cycle, index 0 upward; total 2^IDX_W CE cycles.
REQ-021 ready = 1 only in RUN; during INIT pred_taken = 0, and lk_valid and upd_valid are ignored.
REQ-022 Index, macro undefined: {lk_pc[IDX_W-HIST_W+1:2], GHR}.
REQ-023 pred_taken = MSB of PHT[pred_idx]; pred_ghr = GHR before this cycle's shift.
REQ-024 RUN, lk_valid=1, CE=1, no mispredict repair: GHR <= {GHR[HIST_W-2:0], pred_taken} (speculative shift).
REQ-025 RUN, upd_valid=1, upd_mispredict=1, CE=1: GHR <= {upd_ghr[HIST_W-2:0], upd_taken}; repair overrides a same-cycle lookup shift.
REQ-026 upd_valid=1, CE=1: PHT[upd_idx] increments if taken, decrements if not; saturates at 2^CNT_W-1 and 0.
REQ-027 Lookup and update to the same index in the same cycle: the lookup returns the pre-update counter; the update is still committed.
REQ-028 CE=0: GHR, PHT, FSM and init pointer hold; pred_taken remains combinationally valid.
REQ-029 Each update is independent of every other update; no update is lost or merged.

Reset
REQ-030 rst=0 at posedge: GHR <= 0, init pointer <= 0, state <= INIT, ready = 0 from the next cycle.
REQ-031 Reset asserted mid-INIT or mid-RUN restarts initialisation from entry 0.
REQ-032 PHT contents are defined only by the INIT sweep; there is no per-entry reset.

Configuration
REQ-033 Macro GSHARE_XOR_EN defined: index = lk_pc[IDX_W+1:2] XOR zero-extended GHR (gshare hashing).
REQ-034 Macro GSHARE_XOR_EN undefined: concatenated index per REQ-022.
REQ-035 Ports, FSM, GHR repair and counter behaviour are identical in both builds.

Verification
REQ-036 Scenario: rst=0 1 cycle, then CE=1 -> ready=0 for exactly 128 cycles (defaults), ready=1 on cycle 129; first lookup gives pred_taken=1 (WEAK_T=2).
REQ-037 Scenario: 3 taken updates to idx 5 -> counter 3 (saturated); 4 not-taken updates -> counter 0, pred_taken=0; one further not-taken update -> counter stays 0.
REQ-038 Scenario: GHR=4'b0000, lk_valid with pred_taken=1 -> GHR=4'b0001; same cycle upd_mispredict=1, upd_ghr=4'b1010, upd_taken=0 -> GHR=4'b0100 (repair wins).
REQ-039 Scenario: same-cycle lookup and not-taken update at one index with counter 2 -> pred_taken=1 that cycle; counter=1 and pred_taken=0 the next cycle.
REQ-040 Scenario: rst=0 at init pointer 60 -> pointer restarts at 0; ready rises 128 cycles after reset release; CE=0 held 10 cycles during INIT delays ready by exactly 10 cycles.
REQ-041 Scenario: lk_pc=0x0000_0014, GHR=4'b0011 -> pred_idx=7'h53 with GSHARE_XOR_EN undefined, 7'h06 with GSHARE_XOR_EN defined.
